rsa_sequencer: RTL and testbench
================================

Name: rsa_sequencer

Overview:
FSM controller that owns the RSA modular-exponentiation datapath. It accepts encrypt/load-e/load-n commands on a valid/ready request port and drives the datapath strobes (initialize, en_multiply, en_modulo, done, update_e, update_n). It loops multiply→modulo until the datapath reports multiplication done, then returns the result on a valid/ready response port. It sits between the host command interface and the datapath; at most one command is in flight.

Parameters:
DATA_W, 13, request/datapath data width
OUT_W, 16, result width
E_RESET, 17, reset value of the shadow exponent; matches the datapath power-up e
MAX_ITER, 65535, multiply/modulo loop limit used only when TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready
req_op  in  2  00 encrypt, 01 load e, 10 load n, 11 reserved
req_data  in  DATA_W  plaintext (encrypt) or new e/n value
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  OUT_W  ciphertext; 0 for loads and errors
rsp_err  out  1  1 = rejected or aborted command
busy  out  1  high in every state except IDLE
dp_data  out  DATA_W  registered copy of req_data to the datapath
dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n  out  1 each  datapath strobes
dp_mult_done  in  1  datapath is_multiplication_done
dp_output_data  in  OUT_W  datapath output_data

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE; all outputs 0 except req_ready=1; data_q=0; e_shadow=E_RESET. The datapath has no reset, so host reloads e/n after any reset.
- States: IDLE, LOAD, INIT, CHECK, MUL, MOD, FIN, RESP.
- req_ready=1 only in IDLE. On accept, capture req_data→data_q and req_op→op_q. dp_data=data_q at all times.
- IDLE→LOAD for op 01/10. LOAD pulses dp_update_e or dp_update_n for 1 cycle. Op 01 also sets e_shadow=data_q zero-extended. LOAD→RESP with rsp_data=0, err=0.
- IDLE→RESP with err=1 for op 11, or for op 00 when e_shadow==0 (guards against the iteration-counter wrap).
- Op 00, accept→INIT. INIT pulses dp_initialize→CHECK.
- CHECK drives no strobes. It samples dp_mult_done: 1→FIN, 0→MUL.
- MUL pulses dp_en_multiply→MOD. MOD pulses dp_en_modulo→CHECK.
- FIN pulses dp_done→RESP. In RESP, rsp_data=dp_output_data and err=0.
- RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready, then →IDLE.
- Strobes are mutually exclusive and one cycle wide, asserted combinationally from state.
- Encrypt latency: rsp_valid first high 3·e+1 cycles after the accept edge (e=17 → 52; e=1 → 4).
- Reset mid-operation: immediate return to IDLE; any partial result is discarded.

Optional Feature:
TIMEOUT_EN:
- Defined: a loop counter clears in INIT and increments on each MUL. If it reaches MAX_ITER while in CHECK with dp_mult_done=0, go to RESP with err=1 and rsp_data=0, and do not pulse dp_done.
- Undefined: no counter; the loop runs until dp_mult_done.

Decomposition:
- Shared package rsa_pkg holds:
  - opcode enum: OP_ENC, OP_LD_E, OP_LD_N, OP_RSVD
  - state enum
  - DATA_W/OUT_W constants
  - E_RESET
- Sub-module rsa_loop_watchdog (counter plus compare), instantiated only under TIMEOUT_EN.

Test Plan:
- Reset, then encrypt data=65 with defaults e=17, n=3233 (real datapath model) → rsp_data=2790, err=0, rsp_valid 52 cycles after accept.
- Load e=3, load n=33, encrypt 4 → each load returns rsp_data=0/err=0 after 2 cycles; encrypt returns 31 at cycle 10; strobe trace is INIT, then {MUL,MOD} twice, then FIN.
- Load e=0, then encrypt → err=1 with no datapath strobes; op=11 → err=1; load e=1, encrypt 7 → 7 after 4 cycles.
- Hold rsp_ready=0 for 20 cycles in RESP → outputs stable, req_ready=0; new req_valid is ignored until the handshake completes.
- Assert rst_n low during MUL of an e=17 encrypt → all strobes and rsp_valid drop immediately; after release, busy=0, req_ready=1, and a fresh encrypt gives the correct result.
- TIMEOUT_EN with MAX_ITER=4 and stub dp_mult_done stuck at 0 → err=1 after 4 MULs, dp_done never pulsed.

Source files
------------

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg -- shared definitions for the RSA sequencer slice.
//   * widths of the request/datapath data and of the result
//   * power-up value of the datapath exponent (mirrored by the shadow copy)
//   * command opcode enum and FSM state encoding
// ---------------------------------------------------------------------------
package rsa_pkg;

   localparam int RSA_DATA_W  = 13;
   localparam int RSA_OUT_W   = 16;
   localparam int RSA_E_RESET = 17;

   typedef enum logic [1:0] {
      OP_ENC  = 2'b00,
      OP_LD_E = 2'b01,
      OP_LD_N = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_INIT  = 3'd2;
   localparam state_t ST_CHECK = 3'd3;
   localparam state_t ST_MUL   = 3'd4;
   localparam state_t ST_MOD   = 3'd5;
   localparam state_t ST_FIN   = 3'd6;
   localparam state_t ST_RESP  = 3'd7;

endpackage

// File: rtl/rsa_loop_watchdog.sv
// ---------------------------------------------------------------------------
// rsa_loop_watchdog -- counts multiply passes of one encryption and flags
// when the count reaches MAX_ITER. Only instantiated when TIMEOUT_EN is
// defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (encryption initialise cycle)
//   inc        : one multiply pass taken
//   expired    : count has reached MAX_ITER
// ---------------------------------------------------------------------------
module rsa_loop_watchdog #(
   parameter int MAX_ITER = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_ITER + 1);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (inc && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q >= CNT_W'(MAX_ITER));

endmodule

// File: rtl/rsa_sequencer.sv
// ---------------------------------------------------------------------------
// rsa_sequencer -- command FSM for the RSA modular-exponentiation datapath.
// Accepts encrypt / load-e / load-n commands, sequences the datapath strobes
// (initialise, multiply/modulo loop, done, e/n updates) and returns one
// response per command.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/req_data  command port (valid/ready)
//   rsp_valid/rsp_ready/rsp_data/rsp_err response port (valid/ready)
//   busy                               high whenever not idle
//   dp_data                            registered command data to datapath
//   dp_initialize .. dp_update_n       one-cycle datapath strobes
//   dp_mult_done, dp_output_data       datapath status and result
//
// Optional build macro TIMEOUT_EN: bounds the multiply/modulo loop at
// MAX_ITER passes and aborts the encryption with rsp_err=1 when reached.
// ---------------------------------------------------------------------------
module rsa_sequencer
   import rsa_pkg::*;
#(
   parameter int DATA_W  = RSA_DATA_W,
   parameter int OUT_W   = RSA_OUT_W,
   parameter int E_RESET = RSA_E_RESET
`ifdef TIMEOUT_EN
   ,
   parameter int MAX_ITER = 65535
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [OUT_W-1:0]  rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [DATA_W-1:0] dp_data,
   output logic              dp_initialize,
   output logic              dp_en_multiply,
   output logic              dp_en_modulo,
   output logic              dp_done,
   output logic              dp_update_e,
   output logic              dp_update_n,
   input  logic              dp_mult_done,
   input  logic [OUT_W-1:0]  dp_output_data
);

   state_t            state_q, state_d;
   op_e               op_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] e_shadow_q;   // tracks the datapath exponent
   logic              err_q;        // response is an error
   logic              pass_q;       // response carries datapath output
   logic              timeout;

`ifdef TIMEOUT_EN
   rsa_loop_watchdog #(
      .MAX_ITER (MAX_ITER)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q == ST_INIT),
      .inc     (state_q == ST_MUL),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // NOTE: next state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               case (op_e'(req_op))
                  // A zero exponent would wrap the datapath iteration count.
                  OP_ENC:           state_d = (e_shadow_q == '0) ? ST_RESP : ST_INIT;
                  OP_LD_E, OP_LD_N: state_d = ST_LOAD;
                  default:          state_d = ST_RESP;
               endcase
            end
         end
         ST_LOAD:  state_d = ST_RESP;
         ST_INIT:  state_d = ST_CHECK;
         ST_CHECK: begin
            if (dp_mult_done)  state_d = ST_FIN;
            else if (timeout)  state_d = ST_RESP;
            else               state_d = ST_MUL;
         end
         ST_MUL:   state_d = ST_MOD;
         ST_MOD:   state_d = ST_CHECK;
         ST_FIN:   state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ENC;
         data_q     <= '0;
         e_shadow_q <= DATA_W'(E_RESET);
         err_q      <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  data_q <= req_data;
                  op_q   <= op_e'(req_op);
                  // Only rejected commands jump straight to RESP from IDLE.
                  err_q  <= (state_d == ST_RESP);
                  pass_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (op_q == OP_LD_E) e_shadow_q <= data_q;
            end
            ST_CHECK: begin
               if (state_d == ST_RESP) begin
                  err_q  <= 1'b1;
                  pass_q <= 1'b0;
               end
            end
            ST_FIN: begin
               err_q  <= 1'b0;
               pass_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready      = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign dp_data        = data_q;

   assign dp_initialize  = (state_q == ST_INIT);
   assign dp_en_multiply = (state_q == ST_MUL);
   assign dp_en_modulo   = (state_q == ST_MOD);
   assign dp_done        = (state_q == ST_FIN);
   assign dp_update_e    = (state_q == ST_LOAD) && (op_q == OP_LD_E);
   assign dp_update_n    = (state_q == ST_LOAD) && (op_q == OP_LD_N);

   assign rsp_valid      = (state_q == ST_RESP);
   assign rsp_err        = rsp_valid && err_q;
   assign rsp_data       = (rsp_valid && pass_q) ? dp_output_data : '0;

endmodule

// File: tb/tb_rsa_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rsa_sequencer -- self-checking bench for rsa_sequencer. A behavioural
// datapath (no reset, powers up with e=17, n=3233) answers the strobes;
// expected ciphertexts come from plain modular exponentiation and expected
// latencies from the 3*e+1 rule (accept edge counted as cycle 1).
// ---------------------------------------------------------------------------
module tb_rsa_sequencer;
   import rsa_pkg::*;

   localparam int DW = RSA_DATA_W;
   localparam int OW = RSA_OUT_W;

   localparam logic [5:0] S_INIT = 6'b000001;
   localparam logic [5:0] S_MUL  = 6'b000010;
   localparam logic [5:0] S_MOD  = 6'b000100;
   localparam logic [5:0] S_FIN  = 6'b001000;
   localparam logic [5:0] S_UPE  = 6'b010000;
   localparam logic [5:0] S_UPN  = 6'b100000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'b00;
   logic [DW-1:0] req_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [OW-1:0] rsp_data;
   logic          rsp_err;
   logic          busy;
   logic [DW-1:0] dp_data;
   logic          dp_initialize, dp_en_multiply, dp_en_modulo, dp_done;
   logic          dp_update_e, dp_update_n;
   logic          dp_mult_done;
   logic [OW-1:0] dp_output_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rsa_sequencer u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_data       (req_data),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .busy           (busy),
      .dp_data        (dp_data),
      .dp_initialize  (dp_initialize),
      .dp_en_multiply (dp_en_multiply),
      .dp_en_modulo   (dp_en_modulo),
      .dp_done        (dp_done),
      .dp_update_e    (dp_update_e),
      .dp_update_n    (dp_update_n),
      .dp_mult_done   (dp_mult_done),
      .dp_output_data (dp_output_data)
   );

   // Behavioural datapath: no reset, like the real one.
   logic [DW-1:0] m_e = DW'(17);
   logic [DW-1:0] m_n = DW'(3233);
   longint        m_msg = 0, m_acc = 0, m_prod = 0, m_cnt = 0;

   always @(posedge clk) begin
      if (dp_update_e) m_e <= dp_data;
      if (dp_update_n) m_n <= dp_data;
      if (dp_initialize) begin
         m_msg <= longint'(dp_data);
         m_acc <= longint'(dp_data) % longint'(m_n);
         m_cnt <= 1;
      end
      if (dp_en_multiply) m_prod <= m_acc * m_msg;
      if (dp_en_modulo) begin
         m_acc <= m_prod % longint'(m_n);
         m_cnt <= m_cnt + 1;
      end
   end

   assign dp_mult_done   = (m_cnt >= longint'(m_e));
   assign dp_output_data = OW'(m_acc);

   // Strobe trace, one entry per cycle in which any strobe is high.
   logic [5:0] trace_q[$];
   always @(negedge clk) begin
      if ({dp_update_n, dp_update_e, dp_done, dp_en_modulo, dp_en_multiply, dp_initialize} != 6'b0)
         trace_q.push_back({dp_update_n, dp_update_e, dp_done, dp_en_modulo, dp_en_multiply, dp_initialize});
   end

   // ---------------- reference model helpers ----------------
   function automatic longint modpow(longint m, longint e, longint n);
      longint r = 1;
      for (longint i = 0; i < e; i++) r = (r * m) % n;
      return r;
   endfunction

   function automatic bit enc_trace_ok(int start, int e);
      logic [5:0] exp_q[$];
      exp_q.push_back(S_INIT);
      for (int i = 1; i < e; i++) begin
         exp_q.push_back(S_MUL);
         exp_q.push_back(S_MOD);
      end
      exp_q.push_back(S_FIN);
      if (trace_q.size() - start != exp_q.size()) return 1'b0;
      for (int i = 0; i < exp_q.size(); i++)
         if (trace_q[start + i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic issue(input logic [1:0] op, input logic [DW-1:0] data);
      int waited = 0;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
      end
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Latency counts the accept edge as cycle 1.
   task automatic wait_rsp(output int lat);
      lat = 1;
      for (int i = 0; i < 2000; i++) begin
         if (rsp_valid) break;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] data,
                          output logic [OW-1:0] d, output logic err, output int lat);
      issue(op, data);
      wait_rsp(lat);
      d   = rsp_data;
      err = rsp_err;
      finish_rsp();
   endtask

   // ---------------- tests ----------------
   int ref_e = 17;
   int ref_n = 3233;

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, busy, rsp_valid, rsp_err} !== 4'b1000 || rsp_data !== '0 || dp_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready/busy/valid/err=%b data=%0d dp_data=%0d required 1000/0/0",
                  {req_ready, busy, rsp_valid, rsp_err}, rsp_data, dp_data);
      end
      checks++;
      if ({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes: strobes nonzero, required 0");
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
      end
   endtask

   task automatic test_encrypt(input int m, input string tag);
      logic [OW-1:0] d; logic err; int lat; int start;
      longint exp_d;
      exp_d = modpow(m, ref_e, ref_n);
      start = trace_q.size();
      run_cmd(OP_ENC, DW'(m), d, err, lat);
      checks++;
      if (d !== OW'(exp_d) || err !== 1'b0) begin
         errors++;
         $display("FAIL %s_data: m=%0d e=%0d n=%0d got %0d err=%b required %0d err=0",
                  tag, m, ref_e, ref_n, d, err, exp_d);
      end
      checks++;
      if (lat != 3 * ref_e + 1) begin
         errors++;
         $display("FAIL %s_latency: got %0d required %0d", tag, lat, 3 * ref_e + 1);
      end
      checks++;
      if (!enc_trace_ok(start, ref_e)) begin
         errors++;
         $display("FAIL %s_trace: strobe sequence wrong for e=%0d (%0d entries)",
                  tag, ref_e, trace_q.size() - start);
      end
   endtask

   task automatic test_load(input logic [1:0] op, input int val);
      logic [OW-1:0] d; logic err; int lat; int start;
      start = trace_q.size();
      run_cmd(op, DW'(val), d, err, lat);
      checks++;
      if (d !== '0 || err !== 1'b0 || lat != 2) begin
         errors++;
         $display("FAIL load_rsp: op=%0d got data=%0d err=%b lat=%0d required 0/0/2", op, d, err, lat);
      end
      checks++;
      if (trace_q.size() - start != 1 || trace_q[start] !== ((op == OP_LD_E) ? S_UPE : S_UPN)) begin
         errors++;
         $display("FAIL load_strobe: op=%0d trace entries=%0d required single update", op, trace_q.size() - start);
      end
      if (op == OP_LD_E) ref_e = val;
      else               ref_n = val;
   endtask

   task automatic test_default_encrypt();
      test_encrypt(65, "default_enc");
      checks++;
      if (modpow(65, ref_e, ref_n) != 2790) begin
         errors++;
         $display("FAIL default_ref: reference gives %0d required 2790", modpow(65, ref_e, ref_n));
      end
   endtask

   task automatic test_small_keys();
      test_load(OP_LD_E, 3);
      test_load(OP_LD_N, 33);
      test_encrypt(4, "small_enc");
   endtask

   task automatic test_errors();
      logic [OW-1:0] d; logic err; int lat; int start;
      test_load(OP_LD_E, 0);
      start = trace_q.size();
      run_cmd(OP_ENC, DW'(9), d, err, lat);
      checks++;
      if (err !== 1'b1 || d !== '0 || trace_q.size() != start) begin
         errors++;
         $display("FAIL zero_e: err=%b data=%0d strobes=%0d required 1/0/0", err, d, trace_q.size() - start);
      end
      start = trace_q.size();
      run_cmd(OP_RSVD, DW'(123), d, err, lat);
      checks++;
      if (err !== 1'b1 || d !== '0 || trace_q.size() != start) begin
         errors++;
         $display("FAIL reserved_op: err=%b data=%0d strobes=%0d required 1/0/0", err, d, trace_q.size() - start);
      end
      test_load(OP_LD_E, 1);
      test_encrypt(7, "e1_enc");
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         test_load(OP_LD_E, int'($urandom_range(1, 10)));
         test_load(OP_LD_N, int'($urandom_range(3, 8191)));
         for (int j = 0; j < 3; j++) test_encrypt(int'($urandom_range(0, 8191)), "rand_enc");
      end
   endtask

   task automatic test_backpressure();
      int lat; int start; longint exp_d;
      test_load(OP_LD_E, 5);
      test_load(OP_LD_N, 2021);
      exp_d = modpow(1234, ref_e, ref_n);
      issue(OP_ENC, DW'(1234));
      wait_rsp(lat);
      start = trace_q.size();
      for (int i = 0; i < 20; i++) begin
         req_valid = 1'b1;
         req_op    = OP_LD_E;
         req_data  = DW'(2);
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== OW'(exp_d) || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_rsp: cycle %0d valid=%b data=%0d err=%b ready=%b required 1/%0d/0/0",
                     i, rsp_valid, rsp_data, rsp_err, req_ready, exp_d);
         end
      end
      req_valid = 1'b0;
      finish_rsp();
      checks++;
      if (trace_q.size() != start || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_ignore: strobes=%0d busy=%b required 0/0", trace_q.size() - start, busy);
      end
      test_encrypt(77, "after_hold");
   endtask

   task automatic test_reset_mid();
      int lat; int waited = 0;
      logic [OW-1:0] d; logic err;
      test_load(OP_LD_E, 17);
      test_load(OP_LD_N, 3233);
      issue(OP_ENC, DW'(42));
      while (!dp_en_multiply && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!dp_en_multiply) begin
         errors++;
         $display("FAIL mid_reach_mul: dp_en_multiply=%b required 1", dp_en_multiply);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n, rsp_valid, busy} !== 8'b0
          || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_drop: strobes/valid/busy=%b ready=%b required 0/1",
                  {dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_update_e, dp_update_n, rsp_valid, busy},
                  req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: busy=%b ready=%b valid=%b required 0/1/0", busy, req_ready, rsp_valid);
      end
      // Shadow exponent is back at its reset value, matching the datapath e=17.
      ref_e = RSA_E_RESET;
      test_encrypt(65, "post_reset_enc");
      run_cmd(OP_ENC, DW'(3000), d, err, lat);
      checks++;
      if (d !== OW'(modpow(3000, ref_e, ref_n)) || lat != 3 * ref_e + 1) begin
         errors++;
         $display("FAIL post_reset_enc2: got %0d lat=%0d required %0d lat=%0d",
                  d, lat, modpow(3000, ref_e, ref_n), 3 * ref_e + 1);
      end
   endtask

`ifdef TIMEOUT_EN
   // Second instance with a small loop limit and a datapath that never finishes.
   localparam int WD_ITER = 4;
   logic          wd_req_valid = 1'b0;
   logic          wd_req_ready;
   logic          wd_rsp_valid;
   logic          wd_rsp_ready = 1'b0;
   logic [OW-1:0] wd_rsp_data;
   logic          wd_rsp_err;
   logic          wd_busy;
   logic [DW-1:0] wd_dp_data;
   logic          wd_init, wd_mul, wd_mod, wd_done, wd_upe, wd_upn;
   int            wd_mul_cnt = 0;
   int            wd_done_cnt = 0;

   rsa_sequencer #(
      .MAX_ITER (WD_ITER)
   ) u_dut_wd (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (wd_req_valid),
      .req_ready      (wd_req_ready),
      .req_op         (2'b00),
      .req_data       (DW'(9)),
      .rsp_valid      (wd_rsp_valid),
      .rsp_ready      (wd_rsp_ready),
      .rsp_data       (wd_rsp_data),
      .rsp_err        (wd_rsp_err),
      .busy           (wd_busy),
      .dp_data        (wd_dp_data),
      .dp_initialize  (wd_init),
      .dp_en_multiply (wd_mul),
      .dp_en_modulo   (wd_mod),
      .dp_done        (wd_done),
      .dp_update_e    (wd_upe),
      .dp_update_n    (wd_upn),
      .dp_mult_done   (1'b0),
      .dp_output_data (16'hBEEF)
   );

   always @(negedge clk) begin
      if (wd_mul)  wd_mul_cnt++;
      if (wd_done) wd_done_cnt++;
   end

   task automatic test_timeout();
      int lat = 1;
      int mul0, done0;
      mul0  = wd_mul_cnt;
      done0 = wd_done_cnt;
      wd_req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wd_req_valid = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (wd_rsp_valid) break;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (wd_rsp_valid !== 1'b1 || wd_rsp_err !== 1'b1 || wd_rsp_data !== '0) begin
         errors++;
         $display("FAIL timeout_rsp: valid=%b err=%b data=%0d required 1/1/0", wd_rsp_valid, wd_rsp_err, wd_rsp_data);
      end
      checks++;
      if (wd_mul_cnt - mul0 != WD_ITER || wd_done_cnt != done0 || lat != 3 * WD_ITER + 3) begin
         errors++;
         $display("FAIL timeout_loop: muls=%0d dones=%0d lat=%0d required %0d/0/%0d",
                  wd_mul_cnt - mul0, wd_done_cnt - done0, lat, WD_ITER, 3 * WD_ITER + 3);
      end
      wd_rsp_ready = 1'b1;
      @(negedge clk);
      wd_rsp_ready = 1'b0;
      checks++;
      if (wd_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: busy=%b required 0", wd_busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_default_encrypt();
      test_small_keys();
      test_errors();
      test_random();
      test_backpressure();
      test_reset_mid();
`ifdef TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
